single_cycle_top: RTL and testbench

SINGLE_CYCLE_TOP -- requirements
Module: single_cycle_top

---
 rtl/single_cycle_top.sv | 96 +++++++++
 tb/tb_single_cycle_top.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_top.sv
// single_cycle_top: single-cycle RV32I subset core with internal instruction/data memories.
module single_cycle_top #(
    parameter int    IMEM_WORDS = 1024,
    parameter int    DMEM_WORDS = 1024,
    parameter string IMEM_FILE  = "memfile.hex"
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef SINGLE_CYCLE_JAL_EN
    localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] regs [32];
    logic [31:0] pc, pc_d;
    logic [31:0] instr, rv1, rv2, imm_i, imm_s, imm_b, alu_b, alu_y, addr, wd;
    logic [IAW-1:0] iidx;
    logic [DAW-1:0] didx;
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic we, mw, alu_ok, r_ok;

    assign iidx  = IAW'((pc >> 2) % 32'(IMEM_WORDS));
    assign instr = imem[iidx];
    assign {f7, rs2, rs1, f3, rd, op} = instr;
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign rv1   = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rv2   = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign alu_b = (op == OP_R) ? rv2 : imm_i;
    assign addr  = rv1 + ((op == OP_SW) ? imm_s : imm_i);
    assign didx  = DAW'((addr >> 2) % 32'(DMEM_WORDS));
    assign r_ok  = (f7 == 7'b0000000) || (f7 == 7'b0100000 && f3 == 3'b000);

    always_comb begin
        alu_y  = '0;
        alu_ok = 1'b1;
        case (f3)
            3'b000: alu_y = (op == OP_R && f7[5]) ? rv1 - alu_b : rv1 + alu_b;
            3'b111: alu_y = rv1 & alu_b;
            3'b110: alu_y = rv1 | alu_b;
            3'b100: alu_y = rv1 ^ alu_b;
            3'b010: alu_y = {31'd0, $signed(rv1) < $signed(alu_b)};
            3'b001: begin alu_y = rv1 << alu_b[4:0]; alu_ok = (op == OP_R); end
            3'b101: begin alu_y = rv1 >> alu_b[4:0]; alu_ok = (op == OP_R); end
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        pc_d = pc + 32'd4;
        we   = 1'b0;
        mw   = 1'b0;
        wd   = alu_y;
        case (op)
            OP_R:   we = alu_ok && r_ok;
            OP_I:   we = alu_ok;
            OP_LW:  begin we = (f3 == 3'b010); wd = dmem[didx]; end
            OP_SW:  mw = (f3 == 3'b010);
            OP_BEQ: if (f3 == 3'b000 && rv1 == rv2) pc_d = pc + imm_b;
`ifdef SINGLE_CYCLE_JAL_EN
            OP_JAL: begin
                we   = 1'b1;
                wd   = pc + 32'd4;
                pc_d = pc + {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= '0;
            regs <= '{default: '0};
        end else begin
            pc <= pc_d;
            if (we && rd != 5'd0) regs[rd] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mw) dmem[didx] <= rv2;
    end
endmodule

// File: tb/tb_single_cycle_top.sv
// tb_single_cycle_top: directed vector and sequence checks for single_cycle_top.
module tb_single_cycle_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] prog [$];
    logic [31:0] exp_pc [4];

    typedef struct {
        string       name;
        int          a;
        int          b;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [21];

`ifdef SINGLE_CYCLE_JAL_EN
    localparam bit JAL = 1'b1;
`else
    localparam bit JAL = 1'b0;
`endif

    single_cycle_top #(.IMEM_WORDS(64), .DMEM_WORDS(64), .IMEM_FILE("")) dut (.clk(clk), .rst(rst));

    always #50 clk = ~clk;

    function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
        return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
    endfunction
    function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1, int imm);
        return 32'(((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i('h13, 0, rd, rs1, imm);
    endfunction
    function automatic logic [31:0] enc_s(int rs2, int rs1, int imm);
        return 32'((((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 'h1f) << 7) | 'h23);
    endfunction
    function automatic logic [31:0] enc_b(int rs1, int rs2, int imm);
        return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (((imm >> 1) & 'hf) << 8) | (((imm >> 11) & 1) << 7) | 'h63);
    endfunction
    function automatic logic [31:0] enc_j(int rd, int imm);
        return 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21) | (((imm >> 11) & 1) << 20)
                   | (((imm >> 12) & 'hff) << 12) | (rd << 7) | 'h6f);
    endfunction

    function automatic int nz_regs();
        int c = 0;
        for (int i = 1; i < 32; i++) if (dut.regs[i] !== 32'd0) c++;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic start();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{"add",       5,   -3, enc_r(0, 0, 3, 1, 2),      32'h00000002};
        vecs[1]  = '{"sub",       5,    7, enc_r('h20, 0, 3, 1, 2),   32'hFFFFFFFE};
        vecs[2]  = '{"and",     240,   60, enc_r(0, 7, 3, 1, 2),      32'h00000030};
        vecs[3]  = '{"or",      240,   60, enc_r(0, 6, 3, 1, 2),      32'h000000FC};
        vecs[4]  = '{"xor",     240,   60, enc_r(0, 4, 3, 1, 2),      32'h000000CC};
        vecs[5]  = '{"slt_neg",  -1,    1, enc_r(0, 2, 3, 1, 2),      32'h00000001};
        vecs[6]  = '{"slt_pos",   1,   -1, enc_r(0, 2, 3, 1, 2),      32'h00000000};
        vecs[7]  = '{"sll31",     1,   31, enc_r(0, 1, 3, 1, 2),      32'h80000000};
        vecs[8]  = '{"sll_mask",  3,   33, enc_r(0, 1, 3, 1, 2),      32'h00000006};
        vecs[9]  = '{"srl",     -16,    4, enc_r(0, 5, 3, 1, 2),      32'h0FFFFFFF};
        vecs[10] = '{"add_wrap",  -1,   1, enc_r(0, 0, 3, 1, 2),      32'h00000000};
        vecs[11] = '{"addi_neg",   0,   0, addi(3, 1, -1),            32'hFFFFFFFF};
        vecs[12] = '{"andi",      -1,   0, enc_i('h13, 7, 3, 1, 255), 32'h000000FF};
        vecs[13] = '{"ori_min",    5,   0, enc_i('h13, 6, 3, 1, -2048), 32'hFFFFF805};
        vecs[14] = '{"xori",       5,   0, enc_i('h13, 4, 3, 1, -1),  32'hFFFFFFFA};
        vecs[15] = '{"slti_t",    -5,   0, enc_i('h13, 2, 3, 1, 0),   32'h00000001};
        vecs[16] = '{"slti_f",     5,   0, enc_i('h13, 2, 3, 1, -1),  32'h00000000};
        vecs[17] = '{"mul_nop",    5,   7, enc_r(1, 0, 3, 1, 2),      32'h00000000};
        vecs[18] = '{"slli_nop",   5,   0, enc_i('h13, 1, 3, 1, 1),   32'h00000000};
        vecs[19] = '{"jal_rd",     1,   2, enc_j(3, 8),               JAL ? 32'd12 : 32'd0};
        vecs[20] = '{"sra_nop",  -16,   4, enc_r('h20, 5, 3, 1, 2),   32'h00000000};

        #5 rst = 1'b0;
        #5 check("rst_pc_t10", dut.pc, 32'd0);
        check("rst_regs_t10", 32'(nz_regs()), 32'd0);
        #60 check("rst_pc_t70", dut.pc, 32'd0);
        check("rst_regs_t70", 32'(nz_regs()), 32'd0);
        #70 check("rst_pc_t140", dut.pc, 32'd0);
        check("rst_regs_t140", 32'(nz_regs()), 32'd0);
        #15;

        prog = '{addi(1, 0, 5), addi(2, 0, -3), enc_r(0, 0, 3, 1, 2), enc_r('h20, 0, 4, 2, 1)};
        start();
        run(4);
        check("arith_x1", dut.regs[1], 32'd5);
        check("arith_x2", dut.regs[2], 32'hFFFFFFFD);
        check("arith_x3", dut.regs[3], 32'd2);
        check("arith_x4", dut.regs[4], 32'hFFFFFFF8);

        prog = '{addi(5, 0, 42), enc_s(5, 0, 8), enc_i('h03, 2, 6, 0, 8), enc_i('h03, 2, 7, 0, 11)};
        start();
        run(4);
        check("sw_dmem2", dut.dmem[2], 32'd42);
        check("lw_x6", dut.regs[6], 32'd42);
        check("lw_misaligned_x7", dut.regs[7], 32'd42);

        rst = 1'b0;
        dut.imem[0] = enc_s(0, 0, 8);
        run(3);
        check("rst_no_store", dut.dmem[2], 32'd42);
        check("rst_hold_pc", dut.pc, 32'd0);

        prog = '{addi(1, 0, 1), enc_b(1, 1, 8), addi(2, 0, 9), addi(3, 0, 7)};
        exp_pc = '{32'd0, 32'd4, 32'd12, 32'd16};
        start();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("beq_taken_pc%0d", k), dut.pc, exp_pc[k]);
            run(1);
        end
        check("beq_taken_x2", dut.regs[2], 32'd0);
        check("beq_taken_x3", dut.regs[3], 32'd7);

        prog = '{addi(1, 0, 1), enc_b(1, 0, 8), addi(2, 0, 9), addi(3, 0, 7)};
        exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12};
        start();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("beq_not_pc%0d", k), dut.pc, exp_pc[k]);
            run(1);
        end
        check("beq_not_x2", dut.regs[2], 32'd9);

        prog = '{addi(0, 0, 7), enc_r(0, 0, 1, 0, 0)};
        start();
        run(2);
        check("x0_zero", dut.regs[0], 32'd0);
        check("x0_read_x1", dut.regs[1], 32'd0);

        prog = '{addi(1, 0, 5), addi(1, 1, 1), enc_r(0, 0, 1, 1, 1)};
        start();
        run(3);
        check("rw_same_x1", dut.regs[1], 32'd12);

        prog = '{addi(1, 0, 5), addi(2, 0, 6), addi(3, 0, 7)};
        start();
        run(2);
        check("mid_pre_x2", dut.regs[2], 32'd6);
        #10 rst = 1'b0;
        #1 check("mid_rst_pc", dut.pc, 32'd0);
        check("mid_rst_regs", 32'(nz_regs()), 32'd0);
        #29 rst = 1'b1;
        @(negedge clk);
        check("mid_restart_pc", dut.pc, 32'd4);
        check("mid_restart_x1", dut.regs[1], 32'd5);
        check("mid_restart_x2", dut.regs[2], 32'd0);

        prog = '{addi(2, 0, 1), addi(3, 0, 2), enc_j(1, -4)};
        start();
        run(3);
`ifdef SINGLE_CYCLE_JAL_EN
        check("jal_x1", dut.regs[1], 32'd12);
        check("jal_pc", dut.pc, 32'd4);
`else
        check("jal_nop_x1", dut.regs[1], 32'd0);
        check("jal_nop_pc", dut.pc, 32'd12);
`endif

        for (int v = 0; v < 21; v++) begin
            prog = '{addi(1, 0, vecs[v].a), addi(2, 0, vecs[v].b), vecs[v].instr};
            start();
            run(3);
            check(vecs[v].name, dut.regs[3], vecs[v].exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
